// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//
// Owns the single port of the frame VRAM (12-bit RGB, 2**DW deep, DEPTH used)
// and shares it among three requesters:
//   - display read   : always wins, read data returns one cycle later
//   - fill engine    : writes fill_color to every address 0..DEPTH-1
//   - host writes    : use whatever cycles the display and fill leave free
//
// Ports
//   pclk, rstn        pixel clock, asynchronous active-low reset
//   ven               vertical active from the timing generator
//   disp_ren/raddr    display read request and address
//   disp_rdata        display read data (VRAM data passed straight through)
//   host_wvalid/...   host write handshake, address and RGB data
//   fill_start/color  fill request pulse and fill RGB
//   fill_busy         fill engine armed or writing
//   fill_done         one-cycle pulse after the last fill write
//   oob_err           sticky: accepted host write had address >= DEPTH
//   vram_*            VRAM macro port (synchronous read, 1-cycle latency)
//
// Fill FSM
//   state | meaning
//   IDLE  | no fill in progress, fill_start accepted here only
//   ARM   | fill latched, waiting for the falling edge of ven
//   FILL  | writing color_q at fill_cnt on every cycle the display is idle
//   DONE  | last write issued, fill_done high for this one cycle
// -----------------------------------------------------------------------------
module vram_arbiter #(
  parameter int DW        = 15,
  parameter int H_LEN     = 200,
  parameter int V_LEN     = 150,
  parameter int SYNC_FILL = 1
) (
  input  logic          pclk,
  input  logic          rstn,
  input  logic          ven,
  input  logic          disp_ren,
  input  logic [DW-1:0] disp_raddr,
  output logic [11:0]   disp_rdata,
  input  logic          host_wvalid,
  output logic          host_wready,
  input  logic [DW-1:0] host_waddr,
  input  logic [11:0]   host_wdata,
  input  logic          fill_start,
  input  logic [11:0]   fill_color,
  output logic          fill_busy,
  output logic          fill_done,
  output logic          oob_err,
  output logic [DW-1:0] vram_addr,
  output logic          vram_we,
  output logic [11:0]   vram_wdata,
  input  logic [11:0]   vram_rdata
);

  localparam int            DEPTH   = H_LEN * V_LEN;
  // One extra bit so the range compare cannot overflow when DEPTH == 2**DW.
  localparam logic [DW:0]   DEPTH_X = (DW+1)'(DEPTH);
  localparam logic [DW-1:0] LAST    = DW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  logic [DW-1:0] fill_cnt;
  logic [11:0]   color_q;
  logic          ven_d;

  logic in_fill;
  logic host_xfer;
  logic host_oob;
  logic fill_accept;
  logic ven_fall;

  assign in_fill     = (state == FILL);
  // Gated by rstn so the host never sees an accept while the block is held
  // in reset.
  assign host_wready = rstn && !disp_ren && !in_fill;
  assign host_xfer   = host_wvalid && host_wready;
  assign host_oob    = !({1'b0, host_waddr} < DEPTH_X);
  assign fill_accept = (state == IDLE) && fill_start;
  assign ven_fall    = ven_d && !ven;

  // Display data needs no muxing: only the display ever reads.
  assign disp_rdata = vram_rdata;

  // ---------------------------------------------------------------------------
  // Port mux: display > fill > host.
  // ---------------------------------------------------------------------------
  always_comb begin
    vram_addr  = '0;
    vram_we    = 1'b0;
    vram_wdata = '0;
    if (disp_ren) begin
      vram_addr = disp_raddr;
    end else if (in_fill) begin
      vram_addr  = fill_cnt;
      vram_wdata = color_q;
      vram_we    = 1'b1;
    end else if (host_xfer) begin
      // Out-of-range transfers complete the handshake but never write.
      vram_addr  = host_waddr;
      vram_wdata = host_wdata;
      vram_we    = !host_oob;
    end
  end

  // ---------------------------------------------------------------------------
  // Fill FSM, fill counter and status flags.
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      fill_cnt  <= '0;
      color_q   <= '0;
      ven_d     <= 1'b0;
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
      oob_err   <= 1'b0;
    end else begin
      ven_d     <= ven;
      fill_done <= 1'b0;

      // A bad host write in the same cycle as an accepted fill_start is the
      // newer event, so it keeps the flag set.
      if (host_xfer && host_oob) begin
        oob_err <= 1'b1;
      end else if (fill_accept) begin
        oob_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (fill_start) begin
            color_q   <= fill_color;
            fill_cnt  <= '0;
            fill_busy <= 1'b1;
            state     <= (SYNC_FILL != 0) ? ARM : FILL;
          end
        end
        ARM: begin
          if (ven_fall) begin
            state <= FILL;
          end
        end
        FILL: begin
          // Display cycles stall the engine; nothing moves.
          if (!disp_ren) begin
            if (fill_cnt == LAST) begin
              state     <= DONE;
              fill_busy <= 1'b0;
              fill_done <= 1'b1;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          fill_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

  localparam int DW    = 15;
  localparam int DEPTH = 30000;

  logic          pclk = 1'b0;
  logic          rstn = 1'b0;
  logic          ven = 1'b0;
  logic          disp_ren = 1'b0;
  logic [DW-1:0] disp_raddr = '0;
  logic [11:0]   disp_rdata;
  logic          host_wvalid = 1'b0;
  logic          host_wready;
  logic [DW-1:0] host_waddr = '0;
  logic [11:0]   host_wdata = '0;
  logic          fill_start = 1'b0;
  logic [11:0]   fill_color = '0;
  logic          fill_busy;
  logic          fill_done;
  logic          oob_err;
  logic [DW-1:0] vram_addr;
  logic          vram_we;
  logic [11:0]   vram_wdata;
  logic [11:0]   vram_rdata = '0;

  always #5 pclk = ~pclk;

  vram_arbiter #(.DW(DW), .H_LEN(200), .V_LEN(150), .SYNC_FILL(1)) dut (
    .pclk(pclk), .rstn(rstn), .ven(ven),
    .disp_ren(disp_ren), .disp_raddr(disp_raddr), .disp_rdata(disp_rdata),
    .host_wvalid(host_wvalid), .host_wready(host_wready),
    .host_waddr(host_waddr), .host_wdata(host_wdata),
    .fill_start(fill_start), .fill_color(fill_color),
    .fill_busy(fill_busy), .fill_done(fill_done), .oob_err(oob_err),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata),
    .vram_rdata(vram_rdata)
  );

  // VRAM macro model: synchronous read-first, 1-cycle latency.
  logic [11:0] mem [0:32767];
  always @(posedge pclk) begin
    if (vram_we) mem[vram_addr] <= vram_wdata;
    vram_rdata <= mem[vram_addr];
  end

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] exp_wa [$];
  logic [11:0]   exp_wd [$];
  logic [11:0]   exp_rd [$];
  logic          rd_expect = 1'b0;
  logic          rd_pending = 1'b0;
  int            done_cnt = 0;
  logic [DW-1:0] mon_a;
  logic [11:0]   mon_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic mid();
    @(negedge pclk);
  endtask

  task automatic push_wr(input logic [DW-1:0] a, input logic [11:0] d);
    exp_wa.push_back(a);
    exp_wd.push_back(d);
  endtask

  task automatic rd(input logic [DW-1:0] a, input logic [11:0] e);
    tick();
    disp_ren = 1'b1;
    disp_raddr = a;
    rd_expect = 1'b1;
    exp_rd.push_back(e);
    tick();
    disp_ren = 1'b0;
    rd_expect = 1'b0;
    mid();
  endtask

  always @(posedge pclk) rd_pending <= disp_ren && rd_expect;

  // Monitor: every VRAM write must match the head of the expected-write queue;
  // flagged reads are compared one cycle after their request.
  always @(negedge pclk) begin
    if (rstn) begin
      if (vram_we) begin
        if (exp_wa.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wr_unexpected actual addr=0x%0h data=0x%0h expected no write",
                   vram_addr, vram_wdata);
        end else begin
          mon_a = exp_wa.pop_front();
          mon_d = exp_wd.pop_front();
          chk("wr_addr_data", {vram_addr, vram_wdata}, {mon_a, mon_d});
        end
      end
      if (disp_ren) chk("we_during_disp", {31'b0, vram_we}, 32'd0);
      if (rd_pending) begin
        if (exp_rd.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_unexpected actual=0x%0h expected none", disp_rdata);
        end else begin
          mon_d = exp_rd.pop_front();
          chk("disp_rdata", {20'b0, disp_rdata}, {20'b0, mon_d});
        end
      end
      if (fill_done) done_cnt++;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, cyc, stalls, n, d0;
    bit got_done;

    // Reset values.
    repeat (2) @(posedge pclk);
    mid();
    chk("rst_wready", host_wready, 0);
    chk("rst_busy", fill_busy, 0);
    chk("rst_done", fill_done, 0);
    chk("rst_oob", oob_err, 0);
    chk("rst_we", vram_we, 0);
    tick();
    rstn = 1'b1;

    // Plain host write.
    tick();
    host_wvalid = 1'b1; host_waddr = 15'h0010; host_wdata = 12'hABC;
    push_wr(15'h0010, 12'hABC);
    mid();
    chk("t1_wready", host_wready, 1);
    chk("t1_addr", vram_addr, 32'h10);
    tick();
    host_waddr = 15'h0123; host_wdata = 12'h5A5;
    push_wr(15'h0123, 12'h5A5);
    mid();

    // Display read blocks the host.
    tick();
    disp_ren = 1'b1; disp_raddr = 15'h0123; rd_expect = 1'b1;
    exp_rd.push_back(12'h5A5);
    host_waddr = 15'h0200; host_wdata = 12'h321;
    mid();
    chk("t2_wready", host_wready, 0);
    chk("t2_we", vram_we, 0);
    chk("t2_addr", vram_addr, 32'h123);
    tick();
    disp_ren = 1'b0; rd_expect = 1'b0;
    push_wr(15'h0200, 12'h321);
    mid();
    chk("t2_wready_after", host_wready, 1);
    tick();
    host_wvalid = 1'b0;
    rd(15'h0010, 12'hABC);
    rd(15'h0200, 12'h321);

    // Out-of-range host writes.
    tick();
    host_wvalid = 1'b1; host_waddr = 15'd29999; host_wdata = 12'h777;
    push_wr(15'd29999, 12'h777);
    mid();
    chk("oob_edge_ok", oob_err, 0);
    tick();
    host_waddr = 15'd30000; host_wdata = 12'h888;
    mid();
    chk("oob_wready", host_wready, 1);
    chk("oob_we", vram_we, 0);
    tick();
    host_wvalid = 1'b0;
    mid();
    chk("oob_set", oob_err, 1);
    repeat (5) tick();
    mid();
    chk("oob_sticky", oob_err, 1);

    // Synchronous fill: arm while ven is high.
    tick();
    ven = 1'b1; fill_start = 1'b1; fill_color = 12'hF00;
    mid();
    chk("f1_busy_idle", fill_busy, 0);
    tick();
    fill_start = 1'b0; fill_color = 12'h123;
    mid();
    chk("f1_busy_arm", fill_busy, 1);
    chk("f1_oob_clr", oob_err, 0);
    tick();
    host_wvalid = 1'b1; host_waddr = 15'd30001; host_wdata = 12'h999;
    mid();
    chk("arm_wready", host_wready, 1);
    chk("arm_oob_we", vram_we, 0);
    tick();
    host_waddr = 15'h0300; host_wdata = 12'h456;
    push_wr(15'h0300, 12'h456);
    mid();
    chk("arm_oob_set", oob_err, 1);
    tick();
    host_wvalid = 1'b0; fill_start = 1'b1;
    mid();
    tick();
    fill_start = 1'b0;
    mid();
    chk("arm_start_ignored_oob", oob_err, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      mid();
      chk("arm_busy", fill_busy, 1);
    end
    rd(15'h0300, 12'h456);

    tick();
    for (int i = 0; i < DEPTH; i++) push_wr(15'(i), 12'hF00);
    d0 = done_cnt;
    ven = 1'b0;
    mid();
    chk("arm_edge_no_we", vram_we, 0);
    k = 0; cyc = 0; stalls = 0; got_done = 0;
    while (k < 70000) begin
      tick();
      disp_ren = k[0];
      disp_raddr = 15'(k);
      mid();
      if (fill_done) begin
        got_done = 1;
        break;
      end
      cyc++;
      if (disp_ren) stalls++;
      k++;
    end
    disp_ren = 1'b0;
    chk("f1_done_seen", {31'b0, got_done}, 1);
    chk("f1_cycles", cyc, DEPTH + stalls);
    chk("f1_all_writes", exp_wa.size(), 0);
    chk("f1_busy_done", fill_busy, 0);
    tick();
    mid();
    chk("f1_done_pulse", fill_done, 0);
    chk("f1_done_count", done_cnt - d0, 1);
    chk("f1_oob_kept", oob_err, 1);
    rd(15'd0, 12'hF00);
    rd(15'd29999, 12'hF00);
    rd(15'h0300, 12'hF00);

    // Reset in the middle of a fill.
    tick();
    ven = 1'b1; fill_start = 1'b1; fill_color = 12'h0F0;
    tick();
    fill_start = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 500; i++) push_wr(15'(i), 12'h0F0);
    d0 = done_cnt;
    ven = 1'b0;
    n = 0; k = 0;
    while (k < 2000) begin
      mid();
      if (vram_we) n++;
      if (n == 500) break;
      tick();
      k++;
    end
    chk("rst_fill_500", n, 500);
    @(posedge pclk);
    #1 rstn = 1'b0;
    mid();
    chk("rst_mid_busy", fill_busy, 0);
    chk("rst_mid_we", vram_we, 0);
    chk("rst_mid_done", fill_done, 0);
    chk("rst_mid_oob", oob_err, 0);
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    mid();
    chk("rst_mid_no_done", done_cnt - d0, 0);
    chk("rst_mid_queue", exp_wa.size(), 0);

    // Restart begins at address 0.
    tick();
    ven = 1'b1; fill_start = 1'b1; fill_color = 12'h00F;
    tick();
    fill_start = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 8; i++) push_wr(15'(i), 12'h00F);
    ven = 1'b0;
    n = 0; k = 0;
    while (k < 100) begin
      mid();
      if (vram_we) n++;
      if (n == 8) break;
      tick();
      k++;
    end
    chk("restart_8", n, 8);
    @(posedge pclk);
    #1 rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    mid();
    chk("restart_queue", exp_wa.size(), 0);
    rd(15'd0, 12'h00F);
    rd(15'd8, 12'h0F0);
    rd(15'd600, 12'hF00);
    tick();
    mid();
    chk("rd_queue_empty", exp_rd.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
